// File: rtl/sdram_arb.sv
// Three-port SDRAM arbiter (video, cpu, sd-dma) feeding a controller that holds one command at a time.
// Video has priority but is capped at VID_MAX back-to-back grants while cpu or dma is waiting.
module sdram_arb #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int VID_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      m_req,
    input  logic [2:0]      m_we,
    input  logic [3*AW-1:0] m_adr,
    input  logic [3*DW-1:0] m_wdat,
    output logic [2:0]      m_ack,
    output logic [2:0]      m_rvalid,
    output logic [DW-1:0]   m_rdat,
    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_wdat,
    input  logic            s_ack,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdat
);
    localparam int            CW        = $clog2(VID_MAX + 1);
    localparam logic [CW-1:0] VID_LIMIT = CW'(VID_MAX);
    localparam logic [1:0]    P_VID     = 2'd0;
    localparam logic [1:0]    P_CPU     = 2'd1;
    localparam logic [1:0]    P_DMA     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s_req_q, s_req_d;
    logic          s_we_q, s_we_d;
    logic [AW-1:0] s_adr_q, s_adr_d;
    logic [DW-1:0] s_wdat_q, s_wdat_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] vid_cnt_q, vid_cnt_d;
    logic [1:0]    owner_q, owner_d;

    logic          nv_req;
    logic          vid_sat;
    logic [1:0]    win;

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        port_onehot = 3'b001 << p;
    endfunction

    // Winner selection: video first unless its burst budget is spent and someone else waits.
    always_comb begin
        nv_req  = m_req[1] | m_req[2];
        vid_sat = (vid_cnt_q == VID_LIMIT);
        if (m_req[0] && !(vid_sat && nv_req)) begin
            win = P_VID;
        end else if (m_req[1] && m_req[2]) begin
            win = rr_q ? P_DMA : P_CPU;
        end else if (m_req[1]) begin
            win = P_CPU;
        end else begin
            win = P_DMA;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_adr_d   = s_adr_q;
        s_wdat_d  = s_wdat_q;
        rr_d      = rr_q;
        vid_cnt_d = vid_cnt_q;
        owner_d   = owner_q;
        m_ack     = 3'b000;
        m_rvalid  = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    state_d  = ST_CMD;
                    s_req_d  = 1'b1;
                    s_we_d   = m_we[win];
                    s_adr_d  = m_adr[win*AW +: AW];
                    s_wdat_d = m_wdat[win*DW +: DW];
                    owner_d  = win;
                    if (win == P_VID) begin
                        vid_cnt_d = vid_sat ? vid_cnt_q : vid_cnt_q + CW'(1);
                    end else begin
                        vid_cnt_d = '0;
                        rr_d      = (win == P_CPU);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (s_ack) begin
                    s_req_d = 1'b0;
                    m_ack   = port_onehot(owner_q);
                    state_d = s_we_q ? ST_IDLE : ST_RDWAIT;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RDWAIT: begin
                if (s_rvalid) begin
                    m_rvalid = port_onehot(owner_q);
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RDWAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase
        // The video budget only matters while a non-video port is actually waiting.
        vid_cnt_d = nv_req ? vid_cnt_d : '0;
    end

    // State and latched-command registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_adr_q   <= '0;
            s_wdat_q  <= '0;
            rr_q      <= 1'b0;
            vid_cnt_q <= '0;
            owner_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_adr_q   <= s_adr_d;
            s_wdat_q  <= s_wdat_d;
            rr_q      <= rr_d;
            vid_cnt_q <= vid_cnt_d;
            owner_q   <= owner_d;
        end
    end

    assign s_req  = s_req_q;
    assign s_we   = s_we_q;
    assign s_adr  = s_adr_q;
    assign s_wdat = s_wdat_q;
    assign m_rdat = s_rdat;

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_sdram_arb;
    localparam int AW      = 24;
    localparam int DW      = 16;
    localparam int VID_MAX = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      m_req, m_we, m_ack, m_rvalid;
    logic [3*AW-1:0] m_adr;
    logic [3*DW-1:0] m_wdat;
    logic [DW-1:0]   m_rdat, s_wdat, s_rdat;
    logic            s_req, s_we, s_ack, s_rvalid;
    logic [AW-1:0]   s_adr;

    always #5 clk = ~clk;

    sdram_arb #(.AW(AW), .DW(DW), .VID_MAX(VID_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_adr(m_adr),
        .m_wdat(m_wdat), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdat(m_rdat),
        .s_req(s_req), .s_we(s_we), .s_adr(s_adr), .s_wdat(s_wdat),
        .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdat(s_rdat)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle, 1=command pending, 2=waiting for read data.
    int            ph = 0;
    int            own = 0;
    int            rr = 0;
    int            vc = 0;
    bit            e_sreq = 1'b0;
    bit            e_we = 1'b0;
    logic [AW-1:0] e_adr = '0;
    logic [DW-1:0] e_wdat = '0;

    task automatic model_update();
        int w;
        bit nv;
        nv = m_req[1] | m_req[2];
        if (!rst_n) begin
            ph = 0; own = 0; rr = 0; vc = 0;
            e_sreq = 1'b0; e_we = 1'b0; e_adr = '0; e_wdat = '0;
            return;
        end
        if (ph == 0 && m_req != 3'b000) begin
            if (m_req[0] && !(vc == VID_MAX && nv)) w = 0;
            else if (m_req[1] && m_req[2]) w = (rr == 0) ? 1 : 2;
            else if (m_req[1]) w = 1;
            else w = 2;
            own = w; ph = 1; e_sreq = 1'b1;
            e_we = m_we[w]; e_adr = m_adr[w*AW +: AW]; e_wdat = m_wdat[w*DW +: DW];
            if (w == 0) begin
                if (nv && vc < VID_MAX) vc = vc + 1;
            end else begin
                vc = 0;
                rr = (w == 1) ? 1 : 0;
            end
        end else if (ph == 1 && s_ack) begin
            e_sreq = 1'b0;
            ph = e_we ? 0 : 2;
        end else if (ph == 2 && s_rvalid) begin
            ph = 0;
        end
        if (!nv) vc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [63:0] dut_vec();
        return {s_req, s_we, s_adr, s_wdat, m_ack, m_rvalid,
                (m_rvalid != 3'b000) ? m_rdat : 16'h0000};
    endfunction

    function automatic logic [63:0] exp_vec();
        logic [2:0] ea, ev;
        ea = (ph == 1 && s_ack) ? 3'(1 << own) : 3'b000;
        ev = (ph == 2 && s_rvalid) ? 3'(1 << own) : 3'b000;
        return {e_sreq, e_we, e_adr, e_wdat, ea, ev, (ev != 3'b000) ? s_rdat : 16'h0000};
    endfunction

    function automatic int ack_idx(input logic [2:0] a);
        return a[0] ? 0 : (a[1] ? 1 : 2);
    endfunction

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_we[p] = we;
        m_adr[p*AW +: AW] = a;
        m_wdat[p*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; m_req = 3'b000; s_ack = 1'b0; s_rvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_req = 3'($urandom); m_we = 3'($urandom);
        for (int p = 0; p < 3; p++) set_port(p, 1'($urandom), AW'($urandom), DW'($urandom));
        s_ack = 1'b1; s_rvalid = 1'b1; s_rdat = 16'h5A5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            checks++;
            if ({s_req, s_we, s_adr, s_wdat, m_ack, m_rvalid} !== 48'h0) begin
                errors++;
                $display("FAIL reset_state act=%h exp=0", {s_req, s_we, s_adr, s_wdat, m_ack, m_rvalid});
            end
        end
        rst_n = 1'b1; m_req = 3'b000; s_ack = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic test_single_read();
        apply_reset();
        set_port(1, 1'b0, 24'h000123, 16'h0000);
        m_req = 3'b010;
        tick();
        s_ack = 1'b1;
        #2;
        checks++;
        if ({s_req, s_we, s_adr, m_ack} !== {1'b1, 1'b0, 24'h000123, 3'b010}) begin
            errors++;
            $display("FAIL read_cmd act=%h exp=%h", {s_req, s_we, s_adr, m_ack}, {1'b1, 1'b0, 24'h000123, 3'b010});
        end
        tick();
        m_req = 3'b000; s_ack = 1'b0; s_rvalid = 1'b1; s_rdat = 16'hBEEF;
        #2;
        checks++;
        if ({s_req, m_rvalid, m_rdat} !== {1'b0, 3'b010, 16'hBEEF}) begin
            errors++;
            $display("FAIL read_data act=%h exp=%h", {s_req, m_rvalid, m_rdat}, {1'b0, 3'b010, 16'hBEEF});
        end
        tick();
        s_rvalid = 1'b0;
        #2;
        checks++;
        if (m_rvalid !== 3'b000 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL read_done act=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_rr_writes();
        int order[$];
        int exp_o[4] = '{1, 2, 1, 2};
        int w = 0;
        apply_reset();
        set_port(1, 1'b1, 24'h000100, 16'h1111);
        set_port(2, 1'b1, 24'h000200, 16'h2222);
        m_req = 3'b110;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            tick();
            if (ph == 1) begin
                s_ack = (w == 2);
                w = (w == 2) ? 0 : w + 1;
            end else begin
                s_ack = 1'b0;
                w = 0;
            end
            #2;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_cycle act=%h exp=%h", dut_vec(), exp_vec());
            end
            if (m_ack !== 3'b000) order.push_back(ack_idx(m_ack));
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= order.size() || order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL rr_order[%0d] act=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, exp_o[i]);
            end
        end
        m_req = 3'b000; s_ack = 1'b0;
    endtask

    task automatic test_video_cap();
        int order[$];
        int exp_o[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        apply_reset();
        set_port(0, 1'b1, 24'h00AAAA, 16'hA0A0);
        set_port(1, 1'b1, 24'h00BBBB, 16'hB0B0);
        m_req = 3'b011;
        for (int c = 0; c < 100 && order.size() < 10; c++) begin
            tick();
            s_ack = (ph == 1);
            #2;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL vid_cycle act=%h exp=%h", dut_vec(), exp_vec());
            end
            if (m_ack !== 3'b000) order.push_back(ack_idx(m_ack));
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= order.size() || order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL vid_order[%0d] act=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, exp_o[i]);
            end
        end
        m_req = 3'b000; s_ack = 1'b0;
    endtask

    task automatic test_all_three();
        int order[$];
        int exp_o[3] = '{0, 1, 2};
        logic [2:0] last_ack = 3'b000;
        apply_reset();
        for (int p = 0; p < 3; p++) set_port(p, 1'b1, AW'(p + 16), DW'(p + 32));
        m_req = 3'b111;
        for (int c = 0; c < 60 && order.size() < 3; c++) begin
            tick();
            m_req = m_req & ~last_ack;
            s_ack = (ph == 1);
            #2;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL all3_cycle act=%h exp=%h", dut_vec(), exp_vec());
            end
            last_ack = m_ack;
            if (m_ack !== 3'b000) order.push_back(ack_idx(m_ack));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= order.size() || order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL all3_order[%0d] act=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, exp_o[i]);
            end
        end
        m_req = 3'b000; s_ack = 1'b0;
    endtask

    task automatic test_reset_rdwait();
        apply_reset();
        set_port(2, 1'b0, 24'h0C0DE0, 16'h0000);
        m_req = 3'b100;
        tick();
        s_ack = 1'b1;
        #2;
        checks++;
        if ({s_req, m_ack} !== {1'b1, 3'b100}) begin
            errors++;
            $display("FAIL rst_rd_ack act=%h exp=%h", {s_req, m_ack}, {1'b1, 3'b100});
        end
        tick();
        m_req = 3'b000; s_ack = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        checks++;
        if ({s_req, s_adr} !== {1'b0, 24'h000000}) begin
            errors++;
            $display("FAIL rst_rd_sreq act=%h exp=0", {s_req, s_adr});
        end
        tick();
        s_rvalid = 1'b1; s_rdat = 16'hDEAD;
        #2;
        checks++;
        if (m_rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rst_rd_stale act=%b exp=000", m_rvalid);
        end
        tick();
        s_rvalid = 1'b0;
        set_port(0, 1'b0, 24'h000777, 16'h0000);
        m_req = 3'b001;
        tick();
        #2;
        checks++;
        if ({s_req, s_adr} !== {1'b1, 24'h000777}) begin
            errors++;
            $display("FAIL rst_rd_idle act=%h exp=%h", {s_req, s_adr}, {1'b1, 24'h000777});
        end
        m_req = 3'b000;
    endtask

    task automatic test_latch();
        apply_reset();
        set_port(1, 1'b1, 24'h0ABCDE, 16'h1234);
        m_req = 3'b010;
        tick();
        m_req = 3'b000;
        set_port(1, 1'b0, 24'h055555, 16'h9999);
        for (int i = 0; i < 4; i++) begin
            s_ack = (i == 3);
            #2;
            checks++;
            if ({s_req, s_we, s_adr, s_wdat} !== {1'b1, 1'b1, 24'h0ABCDE, 16'h1234} || m_ack !== (s_ack ? 3'b010 : 3'b000)) begin
                errors++;
                $display("FAIL latch[%0d] act=%h/%b exp=%h", i, {s_req, s_we, s_adr, s_wdat}, m_ack, {1'b1, 1'b1, 24'h0ABCDE, 16'h1234});
            end
            tick();
        end
        s_ack = 1'b0;
        #2;
        checks++;
        if (s_req !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL latch_done act=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [2:0] last_ack = 3'b000;
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int p = 0; p < 3; p++) begin
                if (last_ack[p]) m_req[p] = ($urandom_range(0, 1) == 1);
                else if (!m_req[p]) m_req[p] = ($urandom_range(0, 9) < 3);
                if ((last_ack[p] || !m_req[p]) && $urandom_range(0, 1) == 1)
                    set_port(p, 1'($urandom), AW'($urandom), DW'($urandom));
            end
            s_ack    = (ph == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            s_rvalid = (ph == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            s_rdat   = DW'($urandom);
            if (c == 700) rst_n = 1'b0;
            else rst_n = 1'b1;
            #2;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] act=%h exp=%h", c, dut_vec(), exp_vec());
            end
            last_ack = m_ack;
        end
        m_req = 3'b000; s_ack = 1'b0; s_rvalid = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        m_req = 3'b000; m_we = 3'b000; m_adr = '0; m_wdat = '0;
        s_ack = 1'b0; s_rvalid = 1'b0; s_rdat = '0; rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_rr_writes();
        test_video_cap();
        test_all_three();
        test_reset_rdwait();
        test_latch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
